// File: rtl/fcp_rx_pkg.sv
// Shared types for the FCP credit receiver: credit-table entry, packet FSM
// states, rejection causes and the beats-per-packet helper.
package fcp_rx_pkg;

   typedef struct packed {
      logic [31:0] fccr;
      logic [7:0]  pending;
   } entry_t;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_BODY,
      ST_DISCARD
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_SHORT,
      ERR_LONG,
      ERR_FIELD
   } err_cause_t;

   function automatic int beats_f(input int pkt_len_bytes, input int data_width);
      return pkt_len_bytes / (data_width / 8);
   endfunction

endpackage

// File: rtl/fcp_credit_table.sv
// Per-VC credit table: simple dual-port RAM, one read and one write port,
// registered read data (one cycle latency, old data on same-address collision).
module fcp_credit_table
   import fcp_rx_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output entry_t                rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  entry_t                wr_data
);

   entry_t mem_q [2**ADDR_WIDTH];
   entry_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fcp_credit_receiver.sv
// Packet sink that validates fixed-length packets, tracks per-VC receive
// credits and emits coalesced FCP credit updates back to the injector.
//
// state   | meaning
// INIT    | clearing credit table, one address per cycle, tready low
// IDLE    | waiting for first beat of a packet
// BODY    | counting beats of an accepted packet
// DISCARD | over-length packet already counted as error, drop to tlast
module fcp_credit_receiver
   import fcp_rx_pkg::*;
#(
   parameter int QUEUE_INDEX_WIDTH   = 16,
   parameter int VC_TABLE_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH          = 512,
   parameter int PKT_LEN_BYTES       = 1536,
   parameter int RX_BUFFER_PKTS      = 64,
   parameter int UPDATE_EVERY        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
   input  logic                         s_axis_pkt_tvalid,
   output logic                         s_axis_pkt_tready,
   input  logic                         s_axis_pkt_tlast,
   input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
   output logic                         fcp_valid,
   output logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
   output logic [31:0]                  fcp_fccr,
   output logic [31:0]                  fcp_fccl,
   output logic [31:0]                  fcp_qlen,
   output logic [63:0]                  rx_pkt_count,
   output logic [31:0]                  rx_err_count,
   output logic                         init_done
);

   localparam int QW    = QUEUE_INDEX_WIDTH;
   localparam int AW    = VC_TABLE_ADDR_WIDTH;
   localparam int BEATS = beats_f(PKT_LEN_BYTES, DATA_WIDTH);
   localparam int BCW   = $clog2(BEATS + 1);
   localparam logic [QW:0] VC_LIMIT = (QW+1)'(2**AW);

   state_t         state_q, state_d;
   logic [AW-1:0]  init_cnt_q, init_cnt_d;
   logic [BCW-1:0] left_q, left_d;
   logic [QW-1:0]  vc_q, vc_d;
   logic           err_q, err_d;
   logic           upd_valid_q, upd_valid_d;
   logic [QW-1:0]  upd_vc_q, upd_vc_d;
   logic           fwd_valid_q, fwd_valid_d;
   logic [QW-1:0]  fwd_vc_q, fwd_vc_d;
   entry_t         fwd_entry_q, fwd_entry_d;
   logic           fcp_valid_q, fcp_valid_d;
   logic [QW-1:0]  fcp_vc_q, fcp_vc_d;
   logic [31:0]    fcp_fccr_q, fcp_fccr_d, fcp_fccl_q, fcp_fccl_d, fcp_qlen_q, fcp_qlen_d;
   logic [63:0]    rx_pkt_q, rx_pkt_d;
   logic [31:0]    rx_err_q, rx_err_d;

   logic [QW-1:0]  vc_in;
   logic           vc_bad, keep_bad, beat_err, pkt_done, pkt_err, pkt_good;
   logic [BCW-1:0] beat_left;
   err_cause_t     cause;
   entry_t         rd_data, cur_entry, new_entry, wr_data;
   logic [7:0]     new_pend;
   logic           hit, wr_en;
   logic [AW-1:0]  wr_addr;
   logic           unused_tdata;

   assign vc_in        = s_axis_pkt_tdata[QW-1:0];
   assign vc_bad       = {1'b0, vc_in} >= VC_LIMIT;
   assign keep_bad     = s_axis_pkt_tkeep != '1;
   assign unused_tdata = ^s_axis_pkt_tdata[DATA_WIDTH-1:QW];

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      left_d     = left_q;
      vc_d       = vc_q;
      err_d      = err_q;
      pkt_done   = 1'b0;
      cause      = ERR_NONE;
      beat_left  = (state_q == ST_IDLE) ? BCW'(BEATS) : left_q;
      beat_err   = (state_q == ST_IDLE) ? (vc_bad | keep_bad) : (err_q | keep_bad);
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q - AW'(1);
            if (init_cnt_q == '0) state_d = ST_IDLE;
         end
         ST_IDLE, ST_BODY: begin
            if (s_axis_pkt_tvalid) begin
               left_d = beat_left - BCW'(1);
               err_d  = beat_err;
               if (state_q == ST_IDLE) vc_d = vc_in;
               if (s_axis_pkt_tlast) begin
                  pkt_done = 1'b1;
                  state_d  = ST_IDLE;
                  if (beat_left != BCW'(1)) cause = ERR_SHORT;
                  else if (beat_err)       cause = ERR_FIELD;
               end else if (beat_left == BCW'(1)) begin
                  // error is counted here, so the tail in DISCARD never counts again
                  pkt_done = 1'b1;
                  cause    = ERR_LONG;
                  state_d  = ST_DISCARD;
               end else begin
                  state_d = ST_BODY;
               end
            end
         end
         ST_DISCARD: begin
            if (s_axis_pkt_tvalid && s_axis_pkt_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
      pkt_err  = cause != ERR_NONE;
      pkt_good = pkt_done && !pkt_err;
      upd_valid_d = pkt_good;
      upd_vc_d    = vc_d;
      rx_pkt_d    = rx_pkt_q + 64'(pkt_good);
      rx_err_d    = (pkt_done && pkt_err && rx_err_q != '1) ? rx_err_q + 32'd1 : rx_err_q;
   end

   // The entry written on the previous edge is not yet visible through the
   // read port when the read hits the same edge, so forward it.
   always_comb begin
      cur_entry   = (fwd_valid_q && fwd_vc_q == upd_vc_q) ? fwd_entry_q : rd_data;
      new_pend    = cur_entry.pending + 8'd1;
      hit         = new_pend == 8'(UPDATE_EVERY);
      new_entry.fccr    = cur_entry.fccr + 32'd1;
      new_entry.pending = hit ? 8'd0 : new_pend;
      fwd_valid_d = upd_valid_q;
      fwd_vc_d    = upd_vc_q;
      fwd_entry_d = new_entry;
      fcp_valid_d = upd_valid_q && hit;
      fcp_vc_d    = fcp_vc_q;
      fcp_fccr_d  = fcp_fccr_q;
      fcp_fccl_d  = fcp_fccl_q;
      fcp_qlen_d  = fcp_qlen_q;
      if (fcp_valid_d) begin
         fcp_vc_d   = upd_vc_q;
         fcp_fccr_d = new_entry.fccr;
         fcp_fccl_d = new_entry.fccr + 32'(RX_BUFFER_PKTS);
         fcp_qlen_d = {24'd0, new_pend};
      end
      wr_en   = (state_q == ST_INIT) || upd_valid_q;
      wr_addr = (state_q == ST_INIT) ? init_cnt_q : upd_vc_q[AW-1:0];
      wr_data = (state_q == ST_INIT) ? '0 : new_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '1;
         left_q      <= '0;
         vc_q        <= '0;
         err_q       <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_vc_q    <= '0;
         fwd_valid_q <= 1'b0;
         fwd_vc_q    <= '0;
         fwd_entry_q <= '0;
         fcp_valid_q <= 1'b0;
         fcp_vc_q    <= '0;
         fcp_fccr_q  <= '0;
         fcp_fccl_q  <= '0;
         fcp_qlen_q  <= '0;
         rx_pkt_q    <= '0;
         rx_err_q    <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         left_q      <= left_d;
         vc_q        <= vc_d;
         err_q       <= err_d;
         upd_valid_q <= upd_valid_d;
         upd_vc_q    <= upd_vc_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_vc_q    <= fwd_vc_d;
         fwd_entry_q <= fwd_entry_d;
         fcp_valid_q <= fcp_valid_d;
         fcp_vc_q    <= fcp_vc_d;
         fcp_fccr_q  <= fcp_fccr_d;
         fcp_fccl_q  <= fcp_fccl_d;
         fcp_qlen_q  <= fcp_qlen_d;
         rx_pkt_q    <= rx_pkt_d;
         rx_err_q    <= rx_err_d;
      end
   end

   fcp_credit_table #(
      .ADDR_WIDTH (AW)
   ) u_table (
      .clk     (clk),
      .rd_en   (pkt_good),
      .rd_addr (vc_d[AW-1:0]),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   assign s_axis_pkt_tready = state_q != ST_INIT;
   assign init_done         = state_q != ST_INIT;
   assign fcp_valid         = fcp_valid_q;
   assign fcp_vc            = fcp_vc_q;
   assign fcp_fccr          = fcp_fccr_q;
   assign fcp_fccl          = fcp_fccl_q;
   assign fcp_qlen          = fcp_qlen_q;
   assign rx_pkt_count      = rx_pkt_q;
   assign rx_err_count      = rx_err_q;

endmodule
